// File: rtl/cpu_ctrl_if.sv
// Control bus between the instruction sequencer and the datapath:
// run/decode inputs towards the controller, registered strobes back.
interface cpu_ctrl_if;
  logic       ena;
  logic [2:0] opcode;
  logic       zero;
  logic       inc_pc;
  logic       load_pc;
  logic       load_acc;
  logic       load_ir;
  logic       rd;
  logic       wr;
  logic       datactl_ena;
  logic       halt;
  logic [2:0] step;

  // Datapath / clock-generator side: drives run and decode inputs
  modport master (
    output ena, opcode, zero,
    input  inc_pc, load_pc, load_acc, load_ir, rd, wr, datactl_ena, halt, step
  );

  // Controller side
  modport slave (
    input  ena, opcode, zero,
    output inc_pc, load_pc, load_acc, load_ir, rd, wr, datactl_ena, halt, step
  );
endinterface

// File: rtl/cpu_ctrl.sv
// Eight-step instruction sequencer for the accumulator CPU.
// Each enabled edge registers the strobes decoded for the current step and
// advances the step counter; ena low aborts back to step 0. HLT either parks
// the controller until reset (HALT_STICKY=1) or just pulses halt.
module cpu_ctrl #(
  parameter bit HALT_STICKY = 1'b1
) (
  input logic        sys_clk,
  input logic        rst_n,
  cpu_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    S0, S1, S2, S3, S4, S5, S6, S7
  } step_e;

  typedef enum logic [2:0] {
    OP_HLT = 3'b000,
    OP_SKZ = 3'b001,
    OP_ADD = 3'b010,
    OP_AND = 3'b011,
    OP_XOR = 3'b100,
    OP_LDA = 3'b101,
    OP_STO = 3'b110,
    OP_JMP = 3'b111
  } opcode_e;

  typedef struct packed {
    logic inc_pc;
    logic load_pc;
    logic load_acc;
    logic load_ir;
    logic rd;
    logic wr;
    logic datactl_ena;
    logic halt;
  } strobes_t;

  step_e    step;
  logic     halted;
  strobes_t q;
  strobes_t d;
  opcode_e  op;
  logic     alu_op;

  assign op     = opcode_e'(bus.opcode);
  assign alu_op = (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR) || (op == OP_LDA);

  // Strobe decode for the step about to be evaluated; opcode and zero only
  // influence the steps that reference them
  always_comb begin
    d = '0;
    case (step)
      S0: begin
        d.rd      = 1'b1;
        d.load_ir = 1'b1;
      end
      S1: begin
        d.rd      = 1'b1;
        d.load_ir = 1'b1;
        d.inc_pc  = 1'b1;
      end
      S2: ;
      S3: begin
        d.inc_pc = 1'b1;
        d.halt   = (op == OP_HLT);
      end
      S4: begin
        d.rd          = alu_op;
        d.load_pc     = (op == OP_JMP);
        d.datactl_ena = (op == OP_STO);
      end
      S5: begin
        d.rd          = alu_op;
        d.load_acc    = alu_op;
        d.inc_pc      = ((op == OP_SKZ) && bus.zero) || (op == OP_JMP);
        d.load_pc     = (op == OP_JMP);
        d.datactl_ena = (op == OP_STO);
        d.wr          = (op == OP_STO);
      end
      S6: begin
        d.rd          = alu_op;
        d.datactl_ena = (op == OP_STO);
      end
      S7: d.inc_pc = (op == OP_SKZ) && bus.zero;
      default: ;
    endcase
  end

  // Step counter, halt latch and registered strobes
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      step   <= S0;
      halted <= 1'b0;
      q      <= '0;
    end else if (halted) begin
      q      <= '0;
      q.halt <= 1'b1;
    end else if (!bus.ena) begin
      step <= S0;
      q    <= '0;
    end else begin
      q    <= d;
      step <= step_e'(step + 3'd1);
      if (HALT_STICKY && (step == S3) && (op == OP_HLT))
        halted <= 1'b1;
    end
  end

  assign bus.inc_pc      = q.inc_pc;
  assign bus.load_pc     = q.load_pc;
  assign bus.load_acc    = q.load_acc;
  assign bus.load_ir     = q.load_ir;
  assign bus.rd          = q.rd;
  assign bus.wr          = q.wr;
  assign bus.datactl_ena = q.datactl_ena;
  assign bus.halt        = q.halt;
  assign bus.step        = step;

endmodule

// File: doc/cpu_ctrl.md
CPU_CTRL -- requirements
Module: cpu_ctrl

Interface
REQ-001 The block SHALL have one clock and one reset; reset is asynchronous and active-low.
REQ-002 Parameter: HALT_STICKY, default 1. 1 = HLT parks the controller until reset; 0 = halt pulses for one cycle and the sequence continues.
REQ-003 sys_clk  in  1  clock; all state updates on its rising edge.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 ena  in  1  run enable; driven by the clock generator's fetch phase or a run gate.
REQ-006 opcode  in  3  instruction opcode from the IR.
REQ-007 zero  in  1  accumulator-zero flag.
REQ-008 inc_pc  out  1  PC increment strobe.
REQ-009 load_pc  out  1  PC load-from-operand strobe.
REQ-010 load_acc  out  1  accumulator load strobe.
REQ-011 load_ir  out  1  IR byte load strobe.
REQ-012 rd  out  1  memory read strobe.
REQ-013 wr  out  1  memory write strobe.
REQ-014 datactl_ena  out  1  drives the accumulator onto the data bus.
REQ-015 halt  out  1  halt indication.
REQ-016 step  out  3  current step index, for debug.

Function
REQ-017 Opcode encoding SHALL be: HLT=000, SKZ=001, ADD=010, AND=011, XOR=100, LDA=101, STO=110, JMP=111.
- "ALU op" means ADD, AND, XOR or LDA.
REQ-018 The controller SHALL hold a 3-bit step counter (0..7) plus a HALTED flag.
- All outputs are registered.
REQ-019 On each edge with ena=1 and not HALTED, the block SHALL:
- load the outputs with decode(step, opcode, zero);
- advance step to (step+1) mod 8, wrapping 7 to 0.
REQ-020 decode SHALL be as follows; any strobe not listed is 0.
- step0: rd, load_ir.
- step1: rd, load_ir, inc_pc.
- step2: no strobes.
- step3: inc_pc; HLT also sets halt.
- step4: ALU op gives rd; JMP gives load_pc; STO gives datactl_ena.
- step5: ALU op gives rd and load_acc; SKZ with zero=1 gives inc_pc; JMP gives load_pc and inc_pc; STO gives datactl_ena and wr.
- step6: ALU op gives rd; STO gives datactl_ena.
- step7: SKZ with zero=1 gives inc_pc.
REQ-021 opcode SHALL be sampled only at steps 3-7, and zero only at steps 5 and 7.
- Changes on these inputs at other steps have no effect.
REQ-022 Latency: strobes for step k SHALL be visible in the cycle after the edge that evaluates step k.
- Each strobe is exactly one cycle wide per assertion.
REQ-023 On an edge with ena=0 while not HALTED, the block SHALL abort the instruction:
- step returns to 0;
- all strobes clear to 0 on that edge;
- the next edge with ena=1 restarts at step0.
REQ-024 HLT with HALTED_STICKY=1 (HALT_STICKY=1):
- at the step3 edge, inc_pc=1 and halt=1, and HALTED is set;
- from the next edge on, halt stays 1 and all other strobes stay 0, with step frozen at 4;
- ena is ignored until reset.
REQ-025 HLT with HALT_STICKY=0: halt SHALL be a one-cycle pulse with inc_pc at step3, and the sequence continues normally.
REQ-026 wr and rd SHALL never be asserted in the same cycle, and load_pc SHALL never coincide with load_acc.

Reset
REQ-027 While rst_n=0, all strobes, halt, step and HALTED SHALL be 0, asynchronously.
REQ-028 Reset deasserted mid-instruction SHALL discard that instruction; the first edge with ena=1 after release evaluates step0.

Verification
REQ-029 ADD, ena held 1 from reset, zero=0 -> cycles 1..8 show:
- rd+load_ir;
- rd+load_ir+inc_pc;
- none;
- inc_pc;
- rd;
- rd+load_acc;
- rd;
- none.
Then the sequence repeats.
REQ-030 STO -> step4 gives datactl_ena, step5 gives datactl_ena+wr, step6 gives datactl_ena; rd=0 throughout steps 4-7.
REQ-031 SKZ -> with zero=1, inc_pc at steps 1, 3, 5 and 7 (four pulses); with zero=0, only steps 1 and 3.
REQ-032 JMP -> step4 gives load_pc, step5 gives load_pc+inc_pc; load_acc stays 0.
REQ-033 HLT, HALT_STICKY=1 -> halt rises after the step3 edge and stays 1 across 20 further cycles with ena toggling; step=4 and other strobes 0; rst_n pulse clears everything.
REQ-034 ena dropped at step5 of an ADD -> next cycle all strobes 0 and step=0; ena re-raised gives rd+load_ir one cycle later.
